// File: rtl/load_store_unit.sv
// RV32I memory-access stage: decodes one load/store, runs a single req/ready handshake on the
// data port and returns extended load data or an exception; busy for the whole transaction.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic        exception,
    output logic [31:0] load_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_byte_en,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    localparam logic [6:0]  OP_LOAD  = 7'b0000011;
    localparam logic [6:0]  OP_STORE = 7'b0100011;
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t      r_state;
    logic [15:0] r_cnt;
    logic [2:0]  r_funct3;
    logic [1:0]  r_off;
    logic        r_busy;
    logic        r_done;
    logic        r_exception;
    logic [31:0] r_load_data;
    logic        r_mem_req;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [3:0]  r_mem_byte_en;
    logic [31:0] r_mem_wdata;

    logic        w_is_load;
    logic        w_is_store;
    logic        w_legal;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ld_ext;

    // Request decode: legality (opcode, width, alignment) plus lane pattern and replicated data.
    always_comb begin
        w_is_load  = (opcode == OP_LOAD);
        w_is_store = (opcode == OP_STORE);
        w_legal    = 1'b0;
        w_be       = 4'b0000;
        w_wdata    = store_data;
        case (funct3)
            3'b000: begin
                w_legal = w_is_load | w_is_store;
                w_be    = 4'b0001 << addr[1:0];
                w_wdata = {4{store_data[7:0]}};
            end
            3'b001: begin
                w_legal = (w_is_load | w_is_store) & ~addr[0];
                w_be    = addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{store_data[15:0]}};
            end
            3'b010: begin
                w_legal = (w_is_load | w_is_store) & (addr[1:0] == 2'b00);
                w_be    = 4'b1111;
                w_wdata = store_data;
            end
            3'b100: begin
                w_legal = w_is_load;
                w_be    = 4'b0001 << addr[1:0];
            end
            3'b101: begin
                w_legal = w_is_load & ~addr[0];
                w_be    = addr[1] ? 4'b1100 : 4'b0011;
            end
            default: w_legal = 1'b0;
        endcase
    end

    // Lane extraction uses the offset latched at accept time, not the live addr input.
    always_comb begin
        case (r_off)
            2'd0:    w_byte = mem_rdata[7:0];
            2'd1:    w_byte = mem_rdata[15:8];
            2'd2:    w_byte = mem_rdata[23:16];
            default: w_byte = mem_rdata[31:24];
        endcase
        w_half = r_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (r_funct3)
            3'b000:  w_ld_ext = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_ld_ext = {{16{w_half[15]}}, w_half};
            3'b100:  w_ld_ext = {24'd0, w_byte};
            3'b101:  w_ld_ext = {16'd0, w_half};
            default: w_ld_ext = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_cnt         <= 16'd0;
            r_funct3      <= 3'd0;
            r_off         <= 2'd0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_exception   <= 1'b0;
            r_load_data   <= 32'd0;
            r_mem_req     <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= 32'd0;
            r_mem_byte_en <= 4'd0;
            r_mem_wdata   <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_busy <= 1'b1;
                        if (w_legal) begin
                            r_mem_req     <= 1'b1;
                            r_mem_we      <= w_is_store;
                            r_mem_addr    <= {addr[31:2], 2'b00};
                            r_mem_byte_en <= w_be;
                            r_mem_wdata   <= w_wdata;
                            r_funct3      <= funct3;
                            r_off         <= addr[1:0];
                            r_state       <= S_ACCESS;
                        end else begin
                            r_done      <= 1'b1;
                            r_exception <= 1'b1;
                            r_state     <= S_RESP;
                        end
                    end
                end
                S_ACCESS: begin
                    if (mem_ready) begin
                        r_mem_req   <= 1'b0;
                        r_done      <= 1'b1;
                        r_exception <= 1'b0;
                        if (!r_mem_we) begin
                            r_load_data <= w_ld_ext;
                        end
                        r_state <= S_RESP;
                    end else if (r_cnt == CNT_LAST) begin
                        // This is the last permitted wait cycle: abort so mem_req spans TIMEOUT_CYCLES.
                        r_cnt       <= r_cnt + 16'd1;
                        r_mem_req   <= 1'b0;
                        r_done      <= 1'b1;
                        r_exception <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_RESP: begin
                    r_done      <= 1'b0;
                    r_exception <= 1'b0;
                    r_busy      <= 1'b0;
                    r_cnt       <= 16'd0;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign exception   = r_exception;
    assign load_data   = r_load_data;
    assign mem_req     = r_mem_req;
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_byte_en = r_mem_byte_en;
    assign mem_wdata   = r_mem_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed loads/stores/illegals/timeout/reset.
module tb_load_store_unit;

    localparam int TO = 4;
    localparam logic [6:0] OPL = 7'b0000011;
    localparam logic [6:0] OPS = 7'b0100011;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [6:0]  opcode = '0;
    logic [2:0]  funct3 = '0;
    logic [31:0] addr = '0;
    logic [31:0] store_data = '0;
    logic        busy, done, exception;
    logic [31:0] load_data;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_byte_en;
    logic [31:0] mem_wdata;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;

    typedef struct {
        logic        exc;
        logic [31:0] ld;
        int          cyc;
    } resp_t;

    typedef struct {
        logic        we;
        logic [31:0] a;
        logic [3:0]  be;
        logic [31:0] wd;
    } memx_t;

    resp_t rq[$];
    memx_t mq[$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int mem_wait = 0;
    int wcnt = 0;
    int req_cycles = 0;
    logic [31:0] mem_word = '0;

    load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .opcode      (opcode),
        .funct3      (funct3),
        .addr        (addr),
        .store_data  (store_data),
        .busy        (busy),
        .done        (done),
        .exception   (exception),
        .load_data   (load_data),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_byte_en (mem_byte_en),
        .mem_wdata   (mem_wdata),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory responder: answers after mem_wait request cycles and checks the request attributes.
    always @(negedge clk) begin
        memx_t m;
        if (rst_n && mem_req) begin
            req_cycles++;
            if (wcnt == mem_wait) begin
                mem_ready = 1'b1;
                mem_rdata = mem_word;
                if (mq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL mem_unexpected_req: addr 0x%08h with no expected access", mem_addr);
                end else begin
                    m = mq.pop_front();
                    chk("mem_we", {31'd0, mem_we}, {31'd0, m.we});
                    chk("mem_addr", mem_addr, m.a);
                    chk("mem_byte_en", {28'd0, mem_byte_en}, {28'd0, m.be});
                    if (m.we) chk("mem_wdata", mem_wdata, m.wd);
                end
            end else begin
                mem_ready = 1'b0;
            end
            wcnt++;
        end else begin
            mem_ready = 1'b0;
            wcnt = 0;
        end
    end

    // Response monitor
    always @(negedge clk) begin
        resp_t r;
        if (rst_n && done) begin
            if (rq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: exception=%0d load_data=0x%08h", exception, load_data);
            end else begin
                r = rq.pop_front();
                chk("exception", {31'd0, exception}, {31'd0, r.exc});
                chk("load_data", load_data, r.ld);
                chk("done_cycle", cyc, r.cyc);
            end
        end
    end

    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] sd, input logic exc, input logic [31:0] ld,
                         input int lat, input logic push_mem, input logic [3:0] be,
                         input logic [31:0] wd);
        resp_t r;
        memx_t m;
        @(negedge clk);
        opcode = op; funct3 = f3; addr = a; store_data = sd; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        r.exc = exc; r.ld = ld; r.cyc = cyc + lat - 1;
        rq.push_back(r);
        if (push_mem) begin
            m.we = (op == OPS); m.a = {a[31:2], 2'b00}; m.be = be; m.wd = wd;
            mq.push_back(m);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((rq.size() != 0 || busy) && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) begin
            tests++;
            fails++;
            $display("FAIL wait_idle: busy=%0d pending=%0d after 60 cycles", busy, rq.size());
        end
        @(negedge clk);
    endtask

    initial begin
        int base;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_exception", {31'd0, exception}, 32'd0);
        chk("rst_load_data", load_data, 32'd0);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_byte_en", {28'd0, mem_byte_en}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        mem_wait = 0;
        mem_word = 32'h80FF_1234;
        issue(OPL, 3'b000, 32'h103, 32'h0, 1'b0, 32'hFFFF_FF80, 2, 1'b1, 4'b1000, 32'h0);
        wait_idle();
        mem_word = 32'hBEEF_0000;
        issue(OPL, 3'b101, 32'h202, 32'h0, 1'b0, 32'h0000_BEEF, 2, 1'b1, 4'b1100, 32'h0);
        wait_idle();
        issue(OPL, 3'b001, 32'h202, 32'h0, 1'b0, 32'hFFFF_BEEF, 2, 1'b1, 4'b1100, 32'h0);
        wait_idle();

        issue(OPS, 3'b000, 32'h001, 32'h1234_56A5, 1'b0, 32'hFFFF_BEEF, 2, 1'b1, 4'b0010, 32'hA5A5_A5A5);
        wait_idle();
        issue(OPS, 3'b001, 32'h002, 32'h1234_56A5, 1'b0, 32'hFFFF_BEEF, 2, 1'b1, 4'b1100, 32'h56A5_56A5);
        wait_idle();
        issue(OPS, 3'b010, 32'h000, 32'h1234_56A5, 1'b0, 32'hFFFF_BEEF, 2, 1'b1, 4'b1111, 32'h1234_56A5);
        wait_idle();

        base = req_cycles;
        issue(OPL, 3'b010, 32'h006, 32'h0, 1'b1, 32'hFFFF_BEEF, 1, 1'b0, 4'b0, 32'h0);
        wait_idle();
        issue(OPL, 3'b011, 32'h000, 32'h0, 1'b1, 32'hFFFF_BEEF, 1, 1'b0, 4'b0, 32'h0);
        wait_idle();
        chk("illegal_no_mem_req", req_cycles - base, 32'd0);

        mem_wait = 2;
        mem_word = 32'hCAFE_F00D;
        issue(OPL, 3'b010, 32'h010, 32'h0, 1'b0, 32'hCAFE_F00D, 4, 1'b1, 4'b1111, 32'h0);
        wait_idle();
        mem_wait = 0;
        mem_word = 32'h0000_8000;
        issue(OPL, 3'b100, 32'h101, 32'h0, 1'b0, 32'h0000_0080, 2, 1'b1, 4'b0010, 32'h0);
        wait_idle();
        issue(7'b0110011, 3'b000, 32'h000, 32'h0, 1'b1, 32'h0000_0080, 1, 1'b0, 4'b0, 32'h0);
        wait_idle();

        mem_wait = 1000;
        base = req_cycles;
        issue(OPL, 3'b010, 32'h020, 32'h0, 1'b1, 32'h0000_0080, 1 + TO, 1'b0, 4'b0, 32'h0);
        @(negedge clk);
        opcode = OPS; funct3 = 3'b010; addr = 32'h040; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (4) @(negedge clk);
        chk("timeout_req_cycles", req_cycles - base, TO);
        chk("ignored_start_idle", {31'd0, busy}, 32'd0);

        @(negedge clk);
        opcode = OPL; funct3 = 3'b010; addr = 32'h030; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_done", {31'd0, done}, 32'd0);
        chk("arst_load_data", load_data, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        mem_wait = 0;
        mem_word = 32'h7F00_0000;
        issue(OPL, 3'b000, 32'h003, 32'h0, 1'b0, 32'h0000_007F, 2, 1'b1, 4'b1000, 32'h0);
        wait_idle();
        repeat (3) @(negedge clk);

        chk("resp_queue_empty", rq.size(), 32'd0);
        chk("mem_queue_empty", mq.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
